trigger_crossbar_matrix: RTL and testbench

//   Configurable NUM_IN x NUM_OUT trigger routing matrix: each output selects any input, with optional inversion and

---
 rtl/trigger_crossbar_matrix.sv | 146 ++++++++++++++
 tb/tb_trigger_crossbar_matrix.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_crossbar_matrix.sv
// NUM_IN x NUM_OUT trigger routing matrix. Each output picks any synchronised input and
// forwards it as a level or as a stretched edge pulse, with optional inversion.
module trigger_crossbar_matrix #(
  parameter int NUM_IN      = 12,
  parameter int NUM_OUT     = 12,
  parameter int SYNC_STAGES = 2,
  parameter int LEN_WIDTH   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IN-1:0]  trig_in,
  output logic [NUM_OUT-1:0] trig_out,
  input  logic               cfg_wr_en,
  input  logic               cfg_rd_en,
  input  logic [7:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               cfg_rd_valid
);

  localparam logic [31:0] CFG_MASK = 32'h0000_07FF | (((32'd1 << LEN_WIDTH) - 32'd1) << 16);

  logic [NUM_IN-1:0]    sync_p0 [SYNC_STAGES];
  logic [NUM_IN-1:0]    s, s_d, rise, fall;
  logic [7:0]           sel_cfg  [NUM_OUT];
  logic                 inv_cfg  [NUM_OUT];
  logic [1:0]           mode_cfg [NUM_OUT];
  logic [LEN_WIDTH-1:0] len_cfg  [NUM_OUT];
  logic [LEN_WIDTH-1:0] cnt      [NUM_OUT];
  logic [LEN_WIDTH-1:0] cnt_nxt  [NUM_OUT];
  logic [NUM_OUT-1:0]   src, edge_sel, wr_hit, out_nxt;
  logic [31:0]          rd_word;
  logic                 cfg_unused;

  // Reserved and out-of-range write bits are deliberately dropped.
  assign cfg_unused = ^(cfg_wdata & ~CFG_MASK);

  function automatic logic [31:0] pack_cfg(input logic [7:0] sel, input logic inv,
                                           input logic [1:0] mode, input logic [LEN_WIDTH-1:0] len);
    logic [31:0] w;
    w                 = '0;
    w[7:0]            = sel;
    w[8]              = inv;
    w[10:9]           = mode;
    w[16 +: LEN_WIDTH] = len;
    return w;
  endfunction

  // A zero length still yields a one-cycle pulse, so the reload saturates at zero.
  function automatic logic [LEN_WIDTH-1:0] reload_len(input logic [LEN_WIDTH-1:0] len);
    return (len == '0) ? '0 : len - LEN_WIDTH'(1);
  endfunction

  // Stage p0: input synchroniser and one-cycle edge history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_p0[k] <= '0;
      s_d <= '0;
    end else begin
      sync_p0[0] <= trig_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_p0[k] <= sync_p0[k-1];
      s_d <= s;
    end
  end

  assign s    = sync_p0[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  always_comb begin
    src      = '0;
    edge_sel = '0;
    wr_hit   = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      // Out-of-range selects match no input and leave source and edges at zero.
      for (int i = 0; i < NUM_IN; i++) begin
        if (sel_cfg[j] == 8'(i)) begin
          src[j]      = s[i];
          edge_sel[j] = mode_cfg[j][0] ? fall[i] : rise[i];
        end
      end
      wr_hit[j] = cfg_wr_en && (cfg_addr == 8'(j));
    end
  end

  always_comb begin
    out_nxt = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      cnt_nxt[j] = cnt[j];
      unique case (mode_cfg[j])
        2'd0: out_nxt[j] = 1'b0;
        2'd1: out_nxt[j] = src[j] ^ inv_cfg[j];
        default: begin
          out_nxt[j] = (edge_sel[j] | (cnt[j] != '0)) ^ inv_cfg[j];
          if (edge_sel[j])         cnt_nxt[j] = reload_len(len_cfg[j]);
          else if (cnt[j] != '0)   cnt_nxt[j] = cnt[j] - LEN_WIDTH'(1);
        end
      endcase
      if (wr_hit[j]) cnt_nxt[j] = '0;
    end
  end

  // Stage p1: per-channel configuration, stretch counters and output flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NUM_OUT; j++) begin
        sel_cfg[j]  <= 8'(j % NUM_IN);
        inv_cfg[j]  <= 1'b0;
        mode_cfg[j] <= 2'd1;
        len_cfg[j]  <= LEN_WIDTH'(1);
        cnt[j]      <= '0;
      end
      trig_out <= '0;
    end else begin
      for (int j = 0; j < NUM_OUT; j++) begin
        cnt[j] <= cnt_nxt[j];
        if (wr_hit[j]) begin
          sel_cfg[j]  <= cfg_wdata[7:0];
          inv_cfg[j]  <= cfg_wdata[8];
          mode_cfg[j] <= cfg_wdata[10:9];
          len_cfg[j]  <= cfg_wdata[16 +: LEN_WIDTH];
        end
      end
      trig_out <= out_nxt;
    end
  end

  always_comb begin
    rd_word = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      if (cfg_addr == 8'(j)) rd_word = pack_cfg(sel_cfg[j], inv_cfg[j], mode_cfg[j], len_cfg[j]);
    end
  end

  // Readback samples the pre-write configuration when read and write coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_rdata    <= '0;
      cfg_rd_valid <= 1'b0;
    end else begin
      cfg_rd_valid <= cfg_rd_en;
      if (cfg_rd_en) cfg_rdata <= rd_word;
    end
  end

endmodule

// File: tb/tb_trigger_crossbar_matrix.sv
// Bench for trigger_crossbar_matrix: vector table, hand-written corner sequences and a
// randomized run compared against a window-based behavioural model of the routing rules.
module tb_trigger_crossbar_matrix;

  localparam int NI = 12;
  localparam int NO = 12;
  localparam int SS = 2;
  localparam int LW = 16;
  localparam int NRAND = 300;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NI-1:0] trig_in = '0;
  logic [NO-1:0] trig_out;
  logic          cfg_wr_en = 1'b0;
  logic          cfg_rd_en = 1'b0;
  logic [7:0]    cfg_addr = '0;
  logic [31:0]   cfg_wdata = '0;
  logic [31:0]   cfg_rdata;
  logic          cfg_rd_valid;

  int checks = 0;
  int failures = 0;
  int hi_cnt, run_cnt;
  logic hi_prev;

  typedef struct {
    logic [NI-1:0] stim;
    logic [NO-1:0] want;
  } vec_t;
  vec_t tbl [6];

  logic [NI-1:0] hist [NRAND];
  int m_sel [NO];
  int m_inv [NO];
  int m_mode [NO];
  int m_len [NO];

  trigger_crossbar_matrix #(.NUM_IN(NI), .NUM_OUT(NO), .SYNC_STAGES(SS), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .trig_in(trig_in), .trig_out(trig_out),
    .cfg_wr_en(cfg_wr_en), .cfg_rd_en(cfg_rd_en), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_rd_valid(cfg_rd_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, want);
    end
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
    cfg_addr = a; cfg_wdata = d; cfg_wr_en = 1'b1;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic cfg_read(input string name, input logic [7:0] a, input logic [31:0] want);
    cfg_addr = a; cfg_rd_en = 1'b1;
    tick();
    cfg_rd_en = 1'b0;
    chk({name, "_valid"}, 32'(cfg_rd_valid), 32'd1);
    chk(name, cfg_rdata, want);
    tick();
    chk({name, "_valid_drop"}, 32'(cfg_rd_valid), 32'd0);
    chk({name, "_hold"}, cfg_rdata, want);
  endtask

  task automatic tick_cnt(input int ch);
    tick();
    if (trig_out[ch]) begin
      hi_cnt++;
      if (!hi_prev) run_cnt++;
    end
    hi_prev = trig_out[ch];
  endtask

  task automatic clr_cnt();
    hi_cnt = 0; run_cnt = 0; hi_prev = 1'b0;
  endtask

  function automatic logic [NI-1:0] hv(input int m);
    return (m >= 0) ? hist[m] : '0;
  endfunction

  // Output after clock n: level mode shows the input sampled SS clocks earlier; pulse modes
  // are high when a selected edge occurred within the last max(len,1) clocks.
  function automatic logic [NO-1:0] model(input int n);
    logic [NO-1:0] o;
    logic [NI-1:0] a, b;
    logic v;
    int sel, len;
    o = '0;
    for (int j = 0; j < NO; j++) begin
      sel = m_sel[j];
      len = (m_len[j] == 0) ? 1 : m_len[j];
      v = 1'b0;
      if (m_mode[j] == 1) begin
        a = hv(n - SS);
        if (sel < NI) v = a[sel];
      end else if (m_mode[j] >= 2) begin
        for (int m = n - len + 1; m <= n; m++) begin
          a = hv(m - SS);
          b = hv(m - SS - 1);
          if (sel < NI) begin
            if (m_mode[j] == 2 && a[sel] && !b[sel]) v = 1'b1;
            if (m_mode[j] == 3 && !a[sel] && b[sel]) v = 1'b1;
          end
        end
      end
      o[j] = (m_mode[j] == 0) ? 1'b0 : (v ^ (m_inv[j] != 0));
    end
    return o;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NO-1:0] prev;
    logic [31:0] w;

    tbl[0] = '{stim: 12'hA5A, want: 12'hA5A};
    tbl[1] = '{stim: 12'h5A5, want: 12'h5A5};
    tbl[2] = '{stim: 12'hFFF, want: 12'hFFF};
    tbl[3] = '{stim: 12'h000, want: 12'h000};
    tbl[4] = '{stim: 12'h801, want: 12'h801};
    tbl[5] = '{stim: 12'h3C0, want: 12'h3C0};

    repeat (3) tick();
    chk("rst_trig_out", 32'(trig_out), 32'd0);
    chk("rst_rd_valid", 32'(cfg_rd_valid), 32'd0);
    chk("rst_rdata", cfg_rdata, 32'd0);
    rst = 1'b0;
    tick();
    cfg_read("rd_default_ch4", 8'd4, 32'h0001_0204);
    cfg_read("rd_default_ch11", 8'd11, 32'h0001_020B);

    // identity routing and exact latency
    prev = '0;
    for (int i = 0; i < 6; i++) begin
      trig_in = tbl[i].stim;
      repeat (SS) tick();
      chk($sformatf("tbl%0d_latency_hold", i), 32'(trig_out), 32'(prev));
      tick();
      chk($sformatf("tbl%0d_out", i), 32'(trig_out), 32'(tbl[i].want));
      prev = tbl[i].want;
    end

    // inverted level on ch3 from input 7
    trig_in = '0;
    repeat (4) tick();
    cfg_write(8'd3, 32'h0000_0307);
    trig_in = 12'h080;
    repeat (SS + 1) tick();
    chk("inv_lvl_in1", 32'(trig_out), 32'h080);
    trig_in = 12'h000;
    repeat (SS + 1) tick();
    chk("inv_lvl_in0", 32'(trig_out), 32'h008);

    // pulse stretching on ch0 from input 2
    cfg_write(8'd0, 32'h0005_0402);
    clr_cnt();
    trig_in = 12'h004;
    repeat (20) tick_cnt(0);
    chk("rise_len5_high", 32'(hi_cnt), 32'd5);
    chk("rise_len5_runs", 32'(run_cnt), 32'd1);
    cfg_write(8'd0, 32'h0005_0602);
    clr_cnt();
    trig_in = 12'h000;
    repeat (20) tick_cnt(0);
    chk("fall_len5_high", 32'(hi_cnt), 32'd5);
    chk("fall_len5_runs", 32'(run_cnt), 32'd1);
    cfg_write(8'd0, 32'h0000_0402);
    clr_cnt();
    trig_in = 12'h004;
    repeat (20) tick_cnt(0);
    chk("rise_len0_high", 32'(hi_cnt), 32'd1);

    // retrigger three cycles after the first edge
    trig_in = 12'h000;
    repeat (4) tick();
    cfg_write(8'd0, 32'h0005_0402);
    clr_cnt();
    trig_in = 12'h004;
    tick_cnt(0);
    trig_in = 12'h000;
    tick_cnt(0);
    tick_cnt(0);
    trig_in = 12'h004;
    repeat (20) tick_cnt(0);
    chk("retrig_high", 32'(hi_cnt), 32'd8);
    chk("retrig_runs", 32'(run_cnt), 32'd1);

    // out-of-range select, address and simultaneous read/write
    cfg_write(8'd5, 32'h0000_02C8);
    cfg_read("rd_ch5_oob_sel", 8'd5, 32'h0000_02C8);
    trig_in = 12'hFFF;
    repeat (SS + 1) tick();
    chk("oob_sel_in1", 32'(trig_out[5]), 32'd0);
    trig_in = 12'h000;
    repeat (SS + 1) tick();
    chk("oob_sel_in0", 32'(trig_out[5]), 32'd0);
    cfg_write(8'd200, 32'h0003_0605);
    cfg_read("rd_ch8_after_oob_wr", 8'd8, 32'h0001_0208);
    cfg_read("rd_ch4_nonzero", 8'd4, 32'h0001_0204);
    cfg_read("rd_oob_addr", 8'd200, 32'h0000_0000);
    cfg_addr = 8'd9; cfg_wdata = 32'h0002_0409; cfg_wr_en = 1'b1; cfg_rd_en = 1'b1;
    tick();
    cfg_wr_en = 1'b0; cfg_rd_en = 1'b0;
    chk("rdwr_same_valid", 32'(cfg_rd_valid), 32'd1);
    chk("rdwr_same_old", cfg_rdata, 32'h0001_0209);
    tick();
    cfg_read("rd_ch9_new", 8'd9, 32'h0002_0409);

    // asynchronous reset in the middle of a pulse
    repeat (4) tick();
    trig_in = 12'h004;
    repeat (4) tick();
    chk("pulse_before_rst", 32'(trig_out[0]), 32'd1);
    #2 rst = 1'b1;
    #1 chk("rst_async_out", 32'(trig_out), 32'd0);
    tick();
    rst = 1'b0;
    trig_in = 12'h000;
    tick();
    cfg_read("rd_ch4_after_rst", 8'd4, 32'h0001_0204);
    cfg_read("rd_ch0_after_rst", 8'd0, 32'h0001_0200);

    // randomized configuration and traffic
    for (int j = 0; j < NO; j++) begin
      m_sel[j]  = $urandom_range(13, 0);
      m_inv[j]  = $urandom_range(1, 0);
      m_mode[j] = $urandom_range(3, 0);
      m_len[j]  = $urandom_range(6, 0);
      w = {16'(m_len[j]), 5'($urandom), 2'(m_mode[j]), 1'(m_inv[j]), 8'(m_sel[j])};
      cfg_write(8'(j), w);
      cfg_read($sformatf("rd_rand_ch%0d", j), 8'(j), w & 32'hFFFF_07FF);
    end
    repeat (10) tick();
    for (int n = 0; n < NRAND; n++) begin
      hist[n] = ((n == 0) ? '0 : hist[n-1]) ^ (12'($urandom) & 12'($urandom));
      trig_in = hist[n];
      tick();
      chk($sformatf("rand_n%0d", n), 32'(trig_out), 32'(model(n)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
